pattern_match_logger: RTL and testbench

//   Downstream consumer of the serial pattern detector's one-cycle 'found' pulse.

---
 rtl/pattern_match_logger.sv | 136 +++++++++++++
 tb/tb_pattern_match_logger.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_match_logger.sv
// Timestamps each 'found' pulse from the pattern detector and queues the stamps in a FIFO for a valid/ready reader.
// Optional PATTERN_LOG_DROP_CNT_EN adds a saturating drop_count output, and overflow is then derived from it.
module pattern_match_logger #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       found,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TS_W-1:0]            out_ts,
    output logic [$clog2(DEPTH):0]     out_level,
    output logic [CNT_W-1:0]           match_count,
    output logic                       overflow
`ifdef PATTERN_LOG_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]           drop_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_e;

    logic [TS_W-1:0]  mem [DEPTH];
    logic [TS_W-1:0]  ts;
    logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
    logic [PW-1:0]    level_d;
    logic [TS_W-1:0]  head_d;
    logic [AW-1:0]    head_idx;
    logic [CNT_W-1:0] match_count_d;
    logic             overflow_d;
    logic             push, pop, reject;
    occ_e             occ;
`ifdef PATTERN_LOG_DROP_CNT_EN
    logic [CNT_W-1:0] drop_count_d;
`endif

    // Next-state decode: occupancy, push/pop arbitration, counters
    always_comb begin
        occ           = OCC_PARTIAL;
        wr_ptr_d      = wr_ptr;
        rd_ptr_d      = rd_ptr;
        level_d       = out_level;
        match_count_d = match_count;
        overflow_d    = overflow;
        head_idx      = rd_ptr[AW-1:0];
        head_d        = out_ts;

        if (wr_ptr == rd_ptr) begin
            occ = OCC_EMPTY;
        end else if (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) begin
            occ = OCC_FULL;
        end

        // clr dominates both a pending push and a pending pop
        pop    = !clr && (occ != OCC_EMPTY) && out_ready;
        push   = !clr && found && ((occ != OCC_FULL) || pop);
        reject = !clr && found && !push;

        if (clr) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            level_d       = '0;
            match_count_d = '0;
            overflow_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr + PW'(1);
            if (push && !pop) level_d = out_level + PW'(1);
            if (pop && !push) level_d = out_level - PW'(1);
            if (found && (match_count != CNT_MAX)) match_count_d = match_count + CNT_W'(1);
            overflow_d = overflow | reject;
        end

        // Registered head: take the stamp being written if it lands in the new head slot
        head_idx = rd_ptr_d[AW-1:0];
        if (push && (wr_ptr[AW-1:0] == head_idx)) begin
            head_d = ts;
        end else begin
            head_d = mem[head_idx];
        end
    end

`ifdef PATTERN_LOG_DROP_CNT_EN
    always_comb begin
        drop_count_d = drop_count;
        if (clr) begin
            drop_count_d = '0;
        end else if (reject && (drop_count != CNT_MAX)) begin
            drop_count_d = drop_count + CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts          <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_level   <= '0;
            out_valid   <= 1'b0;
            out_ts      <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
`ifdef PATTERN_LOG_DROP_CNT_EN
            drop_count  <= '0;
`endif
        end else begin
            ts          <= ts + TS_W'(1);
            wr_ptr      <= wr_ptr_d;
            rd_ptr      <= rd_ptr_d;
            out_level   <= level_d;
            out_valid   <= (level_d != '0);
            out_ts      <= head_d;
            match_count <= match_count_d;
`ifdef PATTERN_LOG_DROP_CNT_EN
            drop_count  <= drop_count_d;
            overflow    <= (drop_count_d != '0);
`else
            overflow    <= overflow_d;
`endif
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= ts;
    end

endmodule

// File: tb/tb_pattern_match_logger.sv
// Directed self-checking bench for pattern_match_logger (16-bit stamps, plus a 4-bit-stamp instance for wrap).
module tb_pattern_match_logger;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        found = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_ts;
    logic [3:0]  out_level;
    logic [7:0]  match_count;
    logic        overflow;

    logic        found4 = 1'b0;
    logic        ready4 = 1'b0;
    logic        valid4;
    logic [3:0]  ts4;
    logic [3:0]  level4;
    logic [7:0]  mc4;
    logic        ovf4;
`ifdef PATTERN_LOG_DROP_CNT_EN
    logic [7:0]  drop_count;
    logic [7:0]  drop4;
`endif

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] mts;
    logic [15:0] q[$];

    always #5 clk = ~clk;

    // Reference free-running timestamp
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mts <= '0;
        else        mts <= mts + 16'd1;
    end

    pattern_match_logger #(.DEPTH(8), .TS_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .found(found),
        .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
        .out_level(out_level), .match_count(match_count), .overflow(overflow)
`ifdef PATTERN_LOG_DROP_CNT_EN
        , .drop_count(drop_count)
`endif
    );

    pattern_match_logger #(.DEPTH(8), .TS_W(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .found(found4),
        .out_valid(valid4), .out_ready(ready4), .out_ts(ts4),
        .out_level(level4), .match_count(mc4), .overflow(ovf4)
`ifdef PATTERN_LOG_DROP_CNT_EN
        , .drop_count(drop4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n consecutive pulses; the first 'keep' stamps are expected to be queued
    task automatic pulse(input int n, input int keep);
        found = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i < keep) q.push_back(mts);
            tick();
        end
        found = 1'b0;
    endtask

    task automatic drain(input int n, input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            if (q.size() != 0) chk({tag, "_ts"}, 32'(out_ts), 32'(q.pop_front()));
            tick();
        end
        out_ready = 1'b0;
        chk({tag, "_empty"}, 32'(out_valid), 32'd0);
        chk({tag, "_lvl0"}, 32'(out_level), 32'd0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int drained;
        int budget;

        // Reset values
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(out_level), 32'd0);
        chk("rst_mc", 32'(match_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_ts", 32'(out_ts), 32'd0);
        #9 rst_n = 1'b1;

        // 1: single push at ts=3, one-cycle latency, no bypass
        tick();
        budget = 0;
        while (mts != 16'd3 && budget < 20) begin tick(); budget++; end
        chk("t1_wait", 32'(mts), 32'd3);
        found = 1'b1;
        chk("t1_nobypass", 32'(out_valid), 32'd0);
        tick();
        found = 1'b0;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_ts", 32'(out_ts), 32'd3);
        chk("t1_level", 32'(out_level), 32'd1);
        chk("t1_mc", 32'(match_count), 32'd1);
        q.push_back(16'd3);
        drain(1, "t1_drain");

        // 2: overfill with DEPTH+2 pulses
        do_clr();
        chk("t2_clr_mc", 32'(match_count), 32'd0);
        pulse(10, 8);
        chk("t2_level", 32'(out_level), 32'd8);
        chk("t2_ovf", 32'(overflow), 32'd1);
        chk("t2_mc", 32'(match_count), 32'd10);
`ifdef PATTERN_LOG_DROP_CNT_EN
        chk("t2_drop", 32'(drop_count), 32'd2);
`endif
        chk("t2_hold0", 32'(out_ts), 32'(q[0]));
        tick();
        chk("t2_hold1", 32'(out_ts), 32'(q[0]));
        drain(8, "t2_drain");
        chk("t2_sticky", 32'(overflow), 32'd1);

        // 3: full FIFO with simultaneous push and pop
        do_clr();
        chk("t3_clr_ovf", 32'(overflow), 32'd0);
        pulse(8, 8);
        chk("t3_full", 32'(out_level), 32'd8);
        found = 1'b1;
        out_ready = 1'b1;
        chk("t3_head", 32'(out_ts), 32'(q.pop_front()));
        q.push_back(mts);
        tick();
        found = 1'b0;
        out_ready = 1'b0;
        chk("t3_level", 32'(out_level), 32'd8);
        chk("t3_ovf", 32'(overflow), 32'd0);
        chk("t3_mc", 32'(match_count), 32'd9);
        drain(8, "t3_drain");

        // 4: 4-bit timestamp wrap, stamps 15 then 0
        budget = 0;
        while (mts[3:0] != 4'd15 && budget < 20) begin tick(); budget++; end
        chk("t4_wait", 32'(mts[3:0]), 32'd15);
        found4 = 1'b1;
        tick();
        tick();
        found4 = 1'b0;
        ready4 = 1'b1;
        chk("t4_first", 32'(ts4), 32'd15);
        tick();
        chk("t4_second", 32'(ts4), 32'd0);
        tick();
        ready4 = 1'b0;
        chk("t4_empty", 32'(valid4), 32'd0);
        chk("t4_mc", 32'(mc4), 32'd2);

        // 5: clr with found at level 3
        do_clr();
        pulse(3, 3);
        chk("t5_level3", 32'(out_level), 32'd3);
        clr = 1'b1;
        found = 1'b1;
        tick();
        clr = 1'b0;
        found = 1'b0;
        q.delete();
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_level", 32'(out_level), 32'd0);
        chk("t5_mc", 32'(match_count), 32'd0);
        chk("t5_ovf", 32'(overflow), 32'd0);
        pulse(1, 1);
        drain(1, "t5_tsrun");

        // 6: 300 back-to-back pulses, reader always ready
        do_clr();
        drained = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 302; i++) begin
            found = (i < 300);
            if (out_valid) begin
                if (q.size() != 0) chk("t6_ts", 32'(out_ts), 32'(q.pop_front()));
                else chk("t6_underrun", 32'(out_valid), 32'd0);
                drained++;
            end
            if (i < 300) q.push_back(mts);
            tick();
        end
        found = 1'b0;
        out_ready = 1'b0;
        chk("t6_drained", 32'(drained), 32'd300);
        chk("t6_mc", 32'(match_count), 32'd255);
        chk("t6_ovf", 32'(overflow), 32'd0);
        chk("t6_level", 32'(out_level), 32'd0);

        // 7: async reset mid-cycle at level 5
        pulse(5, 5);
        chk("t7_level5", 32'(out_level), 32'd5);
        #3 rst_n = 1'b0;
        #1;
        chk("t7_valid", 32'(out_valid), 32'd0);
        chk("t7_level", 32'(out_level), 32'd0);
        chk("t7_mc", 32'(match_count), 32'd0);
        #2 rst_n = 1'b1;
        q.delete();
        found = 1'b1;
        tick();
        found = 1'b0;
        chk("t7_ts0", 32'(out_ts), 32'd0);
        chk("t7_valid1", 32'(out_valid), 32'd1);
        chk("t7_mc1", 32'(match_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
